// File: rtl/axi_r_arbiter.sv
// Round-robin arbiter that multiplexes N_SLAVES AXI R sources onto one master R port.
// Whole bursts are granted; the winner keeps the channel until its last beat is accepted.
module axi_r_arbiter #(
  parameter int N_SLAVES   = 4,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 6
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [N_SLAVES-1:0]            slave_valid_i,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] slave_data_i,
  input  logic [N_SLAVES*2-1:0]          slave_resp_i,
  input  logic [N_SLAVES*USER_WIDTH-1:0] slave_user_i,
  input  logic [N_SLAVES*ID_WIDTH-1:0]   slave_id_i,
  input  logic [N_SLAVES-1:0]            slave_last_i,
  output logic [N_SLAVES-1:0]            slave_ready_o,
  output logic                           master_valid_o,
  output logic [DATA_WIDTH-1:0]          master_data_o,
  output logic [1:0]                     master_resp_o,
  output logic [USER_WIDTH-1:0]          master_user_o,
  output logic [ID_WIDTH-1:0]            master_id_o,
  output logic                           master_last_o,
  input  logic                           master_ready_i
);

  localparam int IDX_WIDTH = $clog2(N_SLAVES);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   gnt_q, gnt_d;
  logic [IDX_WIDTH-1:0]   rr_q, rr_d;
  logic [IDX_WIDTH-1:0]   winner, sel;
  logic                   any_valid, locked, hs;

  logic [IDX_WIDTH-1:0]   cand [N_SLAVES];
  logic [DATA_WIDTH-1:0]  data_arr [N_SLAVES];
  logic [1:0]             resp_arr [N_SLAVES];
  logic [USER_WIDTH-1:0]  user_arr [N_SLAVES];
  logic [ID_WIDTH-1:0]    id_arr [N_SLAVES];

  // cand[i] is the i-th source visited when scanning from the round-robin pointer
  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_src
    assign cand[gi]     = IDX_WIDTH'((int'(rr_q) + gi) % N_SLAVES);
    assign data_arr[gi] = slave_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign resp_arr[gi] = slave_resp_i[gi*2 +: 2];
    assign user_arr[gi] = slave_user_i[gi*USER_WIDTH +: USER_WIDTH];
    assign id_arr[gi]   = slave_id_i[gi*ID_WIDTH +: ID_WIDTH];
  end

  // Scan backwards so the earliest candidate in round-robin order wins
  always_comb begin
    winner = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (slave_valid_i[cand[i]]) winner = cand[i];
    end
  end

  assign any_valid = |slave_valid_i;
  assign locked    = (state_q == LOCKED);
  assign sel       = locked ? gnt_q : winner;

  always_comb begin
    slave_ready_o  = '0;
    master_valid_o = locked ? slave_valid_i[gnt_q] : any_valid;
    master_data_o  = data_arr[sel];
    master_resp_o  = resp_arr[sel];
    master_user_o  = user_arr[sel];
    master_id_o    = id_arr[sel];
    master_last_o  = slave_last_i[sel];
    if (locked || any_valid) slave_ready_o[sel] = master_ready_i;
  end

  assign hs = master_valid_o & master_ready_i;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    if (hs && master_last_o) begin
      state_d = IDLE;
      rr_d    = (sel == IDX_WIDTH'(N_SLAVES - 1)) ? '0 : sel + 1'b1;
    end else if (!locked && master_valid_o) begin
      // Lock even on a stalled beat so the presented payload cannot change
      state_d = LOCKED;
      gnt_d   = sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_axi_r_arbiter.sv
// Scoreboard bench for axi_r_arbiter: sources are modelled as beat queues, the
// expected master-side beat order is queued by each scenario and checked on every handshake.
module tb_axi_r_arbiter;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int DW = 64;
  localparam int UW = 6;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic [UW-1:0] user;
    logic          last;
    int            gap;
  } beat_t;

  typedef struct {
    int    src;
    beat_t b;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    s_valid = '0;
  logic [N*DW-1:0] s_data = '0;
  logic [N*2-1:0]  s_resp = '0;
  logic [N*UW-1:0] s_user = '0;
  logic [N*IW-1:0] s_id = '0;
  logic [N-1:0]    s_last = '0;
  logic [N-1:0]    s_ready;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic [1:0]      m_resp;
  logic [UW-1:0]   m_user;
  logic [IW-1:0]   m_id;
  logic            m_last;
  logic            m_ready = 1'b0;

  beat_t        src_q [N][$];
  int           gap_cnt [N];
  exp_t         exp_q [$];
  logic [N-1:0] hs_mask;
  int           n_vec = 0;
  int           n_err = 0;

  axi_r_arbiter #(.N_SLAVES(N), .ID_WIDTH(IW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slave_valid_i(s_valid), .slave_data_i(s_data), .slave_resp_i(s_resp),
    .slave_user_i(s_user), .slave_id_i(s_id), .slave_last_i(s_last),
    .slave_ready_o(s_ready),
    .master_valid_o(m_valid), .master_data_o(m_data), .master_resp_o(m_resp),
    .master_user_o(m_user), .master_id_o(m_id), .master_last_o(m_last),
    .master_ready_i(m_ready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk_beat(input int k, input int tag, input int n, input int len);
    beat_t b;
    b.data = {8'(k), 40'h0, 8'(tag), 8'(n)};
    b.id   = IW'(k * 3 + 1);
    b.resp = 2'(n);
    b.user = UW'(k * 7 + n + tag);
    b.last = (n == len - 1);
    b.gap  = 0;
    return b;
  endfunction

  task automatic add_beat(input int k, input beat_t b);
    if (src_q[k].size() == 0) gap_cnt[k] = b.gap;
    src_q[k].push_back(b);
  endtask

  // Burst from source k; the beat at index bub_at is preceded by bub_len idle cycles
  task automatic burst(input int k, input int len, input int tag, input int bub_at, input int bub_len);
    for (int n = 0; n < len; n++) begin
      beat_t b;
      b = mk_beat(k, tag, n, len);
      if (n == bub_at) b.gap = bub_len;
      add_beat(k, b);
    end
  endtask

  task automatic exp_burst(input int k, input int len, input int tag);
    for (int n = 0; n < len; n++) exp_q.push_back('{k, mk_beat(k, tag, n, len)});
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      beat_t b;
      b = '{default: '0};
      if (src_q[k].size() > 0) b = src_q[k][0];
      s_valid[k]            = (src_q[k].size() > 0) && (gap_cnt[k] == 0);
      s_data[k*DW +: DW]    = b.data;
      s_resp[k*2 +: 2]      = b.resp;
      s_user[k*UW +: UW]    = b.user;
      s_id[k*IW +: IW]      = b.id;
      s_last[k]             = b.last;
    end
  endtask

  task automatic sample();
    exp_t e;
    @(negedge clk);
    hs_mask = s_ready & s_valid;
    check_val("ready_onehot", 64'($countones(s_ready) <= 1), 64'd1);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_hs", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        $display("hs src=%0d id=%h data=%h last=%0b", e.src, m_id, m_data, m_last);
        check_val("slave_ready", 64'(s_ready), 64'(4'b0001 << e.src));
        check_val("data", m_data, e.b.data);
        check_val("id", 64'(m_id), 64'(e.b.id));
        check_val("last", 64'(m_last), 64'(e.b.last));
        check_val("resp", 64'(m_resp), 64'(e.b.resp));
        check_val("user", 64'(m_user), 64'(e.b.user));
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (hs_mask[k] && src_q[k].size() > 0) begin
        void'(src_q[k].pop_front());
        if (src_q[k].size() > 0) gap_cnt[k] = src_q[k][0].gap;
      end else if (gap_cnt[k] > 0) begin
        gap_cnt[k]--;
      end
    end
    drive();
  endtask

  function automatic bit busy();
    for (int k = 0; k < N; k++) if (src_q[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || busy()) && n < 200) begin
      sample();
      advance();
      n++;
    end
    check_val("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    m_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      src_q[k].delete();
      gap_cnt[k] = 0;
    end
    exp_q.delete();
    drive();
    repeat (2) begin
      sample();
      check_val("rst_valid", 64'(m_valid), 64'd0);
      check_val("rst_ready", 64'(s_ready), 64'd0);
      advance();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: idle after reset
    do_reset();
    repeat (5) begin
      sample();
      check_val("idle_valid", 64'(m_valid), 64'd0);
      check_val("idle_ready", 64'(s_ready), 64'd0);
      advance();
    end

    // 2: two 3-beat bursts, whole bursts in order
    do_reset();
    m_ready = 1'b1;
    burst(1, 3, 2, -1, 0);
    burst(2, 3, 2, -1, 0);
    exp_burst(1, 3, 2);
    exp_burst(2, 3, 2);
    drive();
    drain();

    // 3: all sources with single-beat bursts rotate 0,1,2,3,0,...
    do_reset();
    m_ready = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) begin
        burst(k, 1, 16 + r, -1, 0);
        exp_burst(k, 1, 16 + r);
      end
    drive();
    drain();

    // 4: stalled beat from source 3 stays put while source 0 arrives
    do_reset();
    begin
      beat_t b;
      b = mk_beat(3, 4, 0, 1);
      b.data = 64'hA5;
      add_beat(3, b);
      exp_q.push_back('{3, b});
      exp_burst(0, 1, 4);
    end
    drive();
    for (int c = 0; c < 4; c++) begin
      sample();
      check_val("stall_valid", 64'(m_valid), 64'd1);
      check_val("stall_data", m_data, 64'hA5);
      check_val("stall_ready", 64'(s_ready), 64'd0);
      advance();
      if (c == 0) begin
        burst(0, 1, 4, -1, 0);
        drive();
      end
    end
    m_ready = 1'b1;
    drain();

    // 5: bubble mid-burst keeps the lock on source 2
    do_reset();
    m_ready = 1'b1;
    burst(2, 4, 5, 2, 2);
    exp_burst(2, 4, 5);
    exp_burst(1, 1, 5);
    drive();
    sample();
    advance();
    burst(1, 1, 5, -1, 0);
    drive();
    drain();

    // 6: reset mid-burst drops the lock; source 0 goes first afterwards
    do_reset();
    m_ready = 1'b1;
    burst(3, 4, 6, -1, 0);
    exp_burst(3, 4, 6);
    drive();
    repeat (2) begin
      sample();
      advance();
    end
    rst_n   = 1'b0;
    m_ready = 1'b0;
    add_beat(0, mk_beat(0, 6, 0, 1));
    drive();
    // the remaining source-3 beats now come after source 0
    begin
      exp_t e2, e3;
      e2 = exp_q.pop_front();
      e3 = exp_q.pop_front();
      exp_q.push_back('{0, mk_beat(0, 6, 0, 1)});
      exp_q.push_back(e2);
      exp_q.push_back(e3);
    end
    sample();
    check_val("rst_mid_ready", 64'(s_ready), 64'd0);
    advance();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
